// File: rtl/viterbi_pkg.sv
// viterbi_pkg
//   Shared definitions for the K=3 Viterbi decoder datapath and its frame
//   sequencer: code constraint length, trellis size, controller state
//   encoding and the received-symbol-pair type.
package viterbi_pkg;

  localparam int K          = 3;
  localparam int NUM_STATES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FWD   = 3'd1,
    DRAIN = 3'd2,
    TB    = 3'd3,
    FIN   = 3'd4
  } ctrl_state_t;

  typedef logic [1:0] sym_pair_t;

endpackage

// File: rtl/viterbi_ctrl_if.sv
// viterbi_ctrl_if
//   Bundles every non-clock/reset signal of the Viterbi frame sequencer.
//   master : upstream/downstream environment (drives start, in_valid,
//            rx_pair, tb_ready; observes everything else)
//   slave  : the controller itself
//   ADDR_W : survivor-memory address width, must match the controller.
interface viterbi_ctrl_if #(
  parameter int ADDR_W = 8
);
  import viterbi_pkg::*;

  logic              start;
  logic              in_valid;
  logic              in_ready;
  sym_pair_t         rx_pair;
  sym_pair_t         bmc_pair;
  logic              acs_en;
  logic              acs_init;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic              tb_en;
  logic              tb_start;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              tb_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, in_valid, rx_pair, tb_ready,
    input  in_ready, bmc_pair, acs_en, acs_init, mem_wr_en, mem_wr_addr,
           tb_en, tb_start, mem_rd_addr, busy, done
  );

  modport slave (
    input  start, in_valid, rx_pair, tb_ready,
    output in_ready, bmc_pair, acs_en, acs_init, mem_wr_en, mem_wr_addr,
           tb_en, tb_start, mem_rd_addr, busy, done
  );

endinterface

// File: rtl/viterbi_stage_cnt.sv
// viterbi_stage_cnt
//   Loadable up/down counter with enable and a terminal-count flag.
//   clk, rst_n  : clock, asynchronous active-low reset (count -> 0)
//   i_load      : load i_load_val (takes priority over i_en)
//   i_load_val  : value loaded
//   i_en        : step the count by one
//   i_up        : 1 = increment, 0 = decrement
//   o_cnt       : current count (registered)
//   o_tc        : count equals TC_VAL
module viterbi_stage_cnt #(
  parameter int             W      = 8,
  parameter logic [W-1:0]   TC_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_up,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // count register: load has priority over stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= i_up ? (r_cnt + W'(1)) : (r_cnt - W'(1));
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == TC_VAL);

endmodule

// File: rtl/viterbi_ctrl.sv
// viterbi_ctrl
//   Frame sequencer for the K=3 Viterbi decoder. Accepts received pairs over
//   a valid/ready handshake, steps the BMC/ACS bank one trellis stage per
//   accepted pair while addressing survivor-memory writes, then sweeps the
//   survivor memory backwards for traceback and pulses done.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : viterbi_ctrl_if.slave (start, in_valid/in_ready/rx_pair,
//                bmc_pair, acs_en/acs_init, mem_wr_en/mem_wr_addr,
//                tb_en/tb_start/mem_rd_addr/tb_ready, busy, done)
//   FRAME_LEN  : trellis stages per frame (2..4096)
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  viterbi_ctrl_if.slave  bus
);

  localparam int                ADDR_W = $clog2(FRAME_LEN);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] ZERO   = {ADDR_W{1'b0}};

  ctrl_state_t       r_state;
  logic              r_in_ready;
  sym_pair_t         r_bmc_pair;
  logic              r_acs_en;
  logic              r_acs_init;
  logic              r_mem_wr_en;
  logic [ADDR_W-1:0] r_mem_wr_addr;
  logic              r_tb_first;
  logic              r_busy;
  logic              r_done;

  logic              w_hs;
  logic              w_tb_en;
  logic [ADDR_W-1:0] w_wr_cnt;
  logic              w_wr_tc;
  logic [ADDR_W-1:0] w_rd_cnt;
  logic              w_rd_tc;

  assign w_hs    = bus.in_valid && r_in_ready;
  // r_state is registered, so tb_en is a registered qualifier on tb_ready
  assign w_tb_en = (r_state == TB) && bus.tb_ready;

  // Forward stage index; held at LAST on the final handshake so it never
  // steps into unused addresses.
  viterbi_stage_cnt #(.W(ADDR_W), .TC_VAL(LAST)) u_fwd_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     ((r_state == IDLE) && bus.start),
    .i_load_val (ZERO),
    .i_en       (w_hs && !w_wr_tc),
    .i_up       (1'b1),
    .o_cnt      (w_wr_cnt),
    .o_tc       (w_wr_tc)
  );

  // Traceback row address; loaded with LAST on the DRAIN cycle, stops at 0.
  viterbi_stage_cnt #(.W(ADDR_W), .TC_VAL(ZERO)) u_rd_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (r_state == DRAIN),
    .i_load_val (LAST),
    .i_en       (w_tb_en && !w_rd_tc),
    .i_up       (1'b0),
    .o_cnt      (w_rd_cnt),
    .o_tc       (w_rd_tc)
  );

  // sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_in_ready    <= 1'b0;
      r_bmc_pair    <= 2'b00;
      r_acs_en      <= 1'b0;
      r_acs_init    <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_addr <= ZERO;
      r_tb_first    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      // single-cycle strobes default low
      r_acs_en    <= 1'b0;
      r_acs_init  <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state    <= FWD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        FWD: begin
          if (w_hs) begin
            r_bmc_pair    <= bus.rx_pair;
            r_acs_en      <= 1'b1;
            r_mem_wr_en   <= 1'b1;
            r_mem_wr_addr <= w_wr_cnt;
            r_acs_init    <= (w_wr_cnt == ZERO);
            if (w_wr_tc) begin
              r_in_ready <= 1'b0;
              r_state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // last stage's acs_en/mem_wr_en are visible during this cycle
          r_state    <= TB;
          r_tb_first <= 1'b1;
        end
        TB: begin
          if (w_tb_en) begin
            r_tb_first <= 1'b0;
            if (w_rd_tc) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.bmc_pair    = r_bmc_pair;
  assign bus.acs_en      = r_acs_en;
  assign bus.acs_init    = r_acs_init;
  assign bus.mem_wr_en   = r_mem_wr_en;
  assign bus.mem_wr_addr = r_mem_wr_addr;
  assign bus.tb_en       = w_tb_en;
  assign bus.tb_start    = w_tb_en && r_tb_first;
  assign bus.mem_rd_addr = w_rd_cnt;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb_viterbi_ctrl
//   Directed self-checking bench for viterbi_ctrl with FRAME_LEN=8.
module tb_viterbi_ctrl;
  import viterbi_pkg::*;

  localparam int FL = 8;
  localparam int AW = 3;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  viterbi_ctrl_if #(.ADDR_W(AW)) u_if ();

  viterbi_ctrl #(.FRAME_LEN(FL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Forward sweep. Entered in IDLE at posedge+1; returns in TB (or after
  // abort_at handshakes when abort_at < FL).
  task automatic run_fwd(input bit gaps, input bit poke, input int abort_at);
    sym_pair_t pairs [FL];
    int k;
    bit hs;
    pairs = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b10};
    k = 0;
    u_if.start    = 1'b1;
    u_if.in_valid = poke;          // pair offered alongside start must not be taken
    u_if.rx_pair  = 2'b11;
    #1;
    chk("idle_in_ready", u_if.in_ready, 0);
    step();
    u_if.start = 1'b0;
    chk("start_no_acs", u_if.acs_en, 0);
    chk("start_busy", u_if.busy, 1);
    for (int cyc = 0; cyc < 40 && k < FL && k < abort_at; cyc++) begin
      u_if.in_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
      u_if.rx_pair  = pairs[k];
      u_if.start    = poke && (cyc == 3);
      hs = u_if.in_valid;
      chk("fwd_in_ready", u_if.in_ready, 1);
      step();
      u_if.start = 1'b0;
      chk("acs_en", u_if.acs_en, hs);
      chk("mem_wr_en", u_if.mem_wr_en, hs);
      if (hs) begin
        chk("wr_addr", u_if.mem_wr_addr, k);
        chk("acs_init", u_if.acs_init, (k == 0));
        chk("bmc_pair", u_if.bmc_pair, pairs[k]);
        k++;
      end
    end
    u_if.in_valid = 1'b0;
    if (abort_at < FL) begin
      chk("abort_stage", k, abort_at);
    end else begin
      chk("fwd_stages", k, FL);
      chk("drain_in_ready", u_if.in_ready, 0);
      step();
      chk("tb_entry_acs", u_if.acs_en, 0);
      chk("tb_entry_addr", u_if.mem_rd_addr, FL - 1);
      chk("tb_entry_busy", u_if.busy, 1);
    end
  endtask

  // Traceback sweep. mode 0: tb_ready held high; mode 1: pattern 1,0,0,1...
  task automatic run_tb(input bit mode, input bit poke);
    int exp_addr;
    int n_tb;
    bit fin;
    exp_addr = FL - 1;
    n_tb = 0;
    fin = 1'b0;
    for (int i = 0; i < 40 && !fin; i++) begin
      u_if.tb_ready = mode ? ((i % 4) == 0 || (i % 4) == 3) : 1'b1;
      u_if.start    = poke && (i == 2);
      #1;
      chk("tb_en", u_if.tb_en, u_if.tb_ready);
      chk("rd_addr", u_if.mem_rd_addr, exp_addr);
      chk("tb_start", u_if.tb_start, u_if.tb_ready && (n_tb == 0));
      chk("tb_done_low", u_if.done, 0);
      if (u_if.tb_ready) begin
        n_tb++;
        if (exp_addr == 0) fin = 1'b1;
        else exp_addr--;
      end
      step();
      u_if.start = 1'b0;
    end
    chk("tb_rows", n_tb, FL);
    chk("fin_done", u_if.done, 1);
    chk("fin_busy", u_if.busy, 1);
    chk("fin_no_tb_en", u_if.tb_en, 0);
    u_if.tb_ready = 1'b0;
    step();
    chk("idle_done", u_if.done, 0);
    chk("idle_busy", u_if.busy, 0);
    chk("idle_rd_addr", u_if.mem_rd_addr, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, u_if.in_ready, 0);
    chk({tag, "_bmc"}, u_if.bmc_pair, 0);
    chk({tag, "_acs_en"}, u_if.acs_en, 0);
    chk({tag, "_acs_init"}, u_if.acs_init, 0);
    chk({tag, "_wr_en"}, u_if.mem_wr_en, 0);
    chk({tag, "_wr_addr"}, u_if.mem_wr_addr, 0);
    chk({tag, "_tb_en"}, u_if.tb_en, 0);
    chk({tag, "_rd_addr"}, u_if.mem_rd_addr, 0);
    chk({tag, "_busy"}, u_if.busy, 0);
    chk({tag, "_done"}, u_if.done, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    u_if.start    = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.rx_pair  = 2'b00;
    u_if.tb_ready = 1'b0;
    #1;
    chk_all_zero("rst");
    step();
    step();
    rst_n = 1'b1;
    step();

    // in_valid high in IDLE without start: nothing consumed
    u_if.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("idle_valid_ready", u_if.in_ready, 0);
      step();
      chk("idle_valid_acs", u_if.acs_en, 0);
      chk("idle_valid_busy", u_if.busy, 0);
    end
    u_if.in_valid = 1'b0;

    // back-to-back frame, tb_ready held high
    run_fwd(1'b0, 1'b0, FL);
    run_tb(1'b0, 1'b0);

    // gapped frame with start pokes and in_valid with start, toggled tb_ready
    run_fwd(1'b1, 1'b1, FL);
    run_tb(1'b1, 1'b1);

    // reset mid-frame after stage 5 has been written
    run_fwd(1'b0, 1'b0, 6);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", u_if.done, 0);
    end
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", u_if.busy, 0);

    // fresh frame after reset restarts at stage 0
    run_fwd(1'b0, 1'b0, FL);
    run_tb(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
